// File: rtl/bpu_pkg.sv
// bpu_pkg: shared encodings and sizes for the branch predict unit
package bpu_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_state_e;
  localparam logic [1:0] RST_STATE = ST;
  localparam int BHT_DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: 2-bit saturating taken/not-taken counter
module sat_counter2
  import bpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       upd_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);
  logic [1:0] nxt;
  always_comb nxt = taken_i ? (state_o == ST ? state_o : state_o + 2'd1)
                            : (state_o == SNT ? state_o : state_o - 2'd1);
  always_ff @(posedge clk_i)
    state_o <= rst_i ? RST_STATE : upd_i ? nxt : state_o;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit branch predictor with misprediction flush/redirect; BPU_BHT_EN selects a 16-entry BHT over one global counter
module branch_predict_unit
  import bpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ID_PC_i,
  output logic        Predict_o,
  input  logic        EX_Branch_i,
  input  logic        EX_Predict_i,
  input  logic        EX_Taken_i,
  input  logic [31:0] EX_PC_i,
  input  logic [31:0] EX_Imm_i,
  output logic        Flush_o,
  output logic [31:0] RedirectPC_o,
  output logic [CNT_W-1:0] MispredCnt_o
);
`ifdef BPU_BHT_EN
  logic [1:0] cnt [BHT_DEPTH];
  logic unused_pc;
  assign unused_pc = ^{ID_PC_i[31:6], ID_PC_i[1:0], EX_Imm_i[31]};
  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    sat_counter2 u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .upd_i   (EX_Branch_i && EX_PC_i[IDX_W+1:2] == IDX_W'(i)),
      .taken_i (EX_Taken_i),
      .state_o (cnt[i])
    );
  end
  assign Predict_o = cnt[ID_PC_i[IDX_W+1:2]][1];
`else
  logic [1:0] cnt;
  logic unused_pc;
  assign unused_pc = ^{ID_PC_i, EX_Imm_i[31]};
  sat_counter2 u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .upd_i   (EX_Branch_i),
    .taken_i (EX_Taken_i),
    .state_o (cnt)
  );
  assign Predict_o = cnt[1];
`endif
  assign Flush_o = EX_Branch_i & (EX_Predict_i ^ EX_Taken_i);
  assign RedirectPC_o = EX_PC_i + (EX_Taken_i ? {EX_Imm_i[30:0], 1'b0} : 32'd4);
  always_ff @(posedge clk_i)
    MispredCnt_o <= rst_i ? '0 : (Flush_o && MispredCnt_o != '1) ? MispredCnt_o + 1'b1 : MispredCnt_o;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and random checks against a behavioural predictor model; honours BPU_BHT_EN
module tb_branch_predict_unit;
  logic        clk = 0;
  logic        rst_i = 0;
  logic [31:0] ID_PC_i = 0;
  logic        Predict_o;
  logic        EX_Branch_i = 0, EX_Predict_i = 0, EX_Taken_i = 0;
  logic [31:0] EX_PC_i = 0, EX_Imm_i = 0;
  logic        Flush_o;
  logic [31:0] RedirectPC_o;
  logic [15:0] MispredCnt_o;

  int n_assert = 0, n_fail = 0;
  int m_cnt [16];
  int m_mis = 0;
`ifdef BPU_BHT_EN
  localparam int IDX_MASK = 15;
`else
  localparam int IDX_MASK = 0;
`endif

  branch_predict_unit dut (
    .clk_i(clk), .rst_i(rst_i), .ID_PC_i(ID_PC_i), .Predict_o(Predict_o),
    .EX_Branch_i(EX_Branch_i), .EX_Predict_i(EX_Predict_i), .EX_Taken_i(EX_Taken_i),
    .EX_PC_i(EX_PC_i), .EX_Imm_i(EX_Imm_i), .Flush_o(Flush_o),
    .RedirectPC_o(RedirectPC_o), .MispredCnt_o(MispredCnt_o)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[5:2]) & IDX_MASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check all outputs against the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic br, input logic pr, input logic tk,
                      input logic [31:0] idpc, input logic [31:0] expc, input logic [31:0] imm);
    logic [31:0] exp_redir;
    logic exp_flush;
    rst_i = rst; EX_Branch_i = br; EX_Predict_i = pr; EX_Taken_i = tk;
    ID_PC_i = idpc; EX_PC_i = expc; EX_Imm_i = imm;
    #1;
    exp_flush = br && (pr != tk);
    exp_redir = tk ? expc + imm * 2 : expc + 32'd4;
    chk("predict", {31'b0, Predict_o}, {31'b0, m_cnt[idx(idpc)] >= 2});
    chk("flush", {31'b0, Flush_o}, {31'b0, exp_flush});
    chk("redirect", RedirectPC_o, exp_redir);
    chk("mispred_cnt", {16'b0, MispredCnt_o}, m_mis);
    @(posedge clk);
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 3;
      m_mis = 0;
    end else begin
      if (br) m_cnt[idx(expc)] = tk ? (m_cnt[idx(expc)] == 3 ? 3 : m_cnt[idx(expc)] + 1)
                                    : (m_cnt[idx(expc)] == 0 ? 0 : m_cnt[idx(expc)] - 1);
      if (exp_flush && m_mis < 65535) m_mis++;
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    @(negedge clk);
    rst_i = 1;
    @(posedge clk);
    foreach (m_cnt[i]) m_cnt[i] = 3;
    m_mis = 0;
    @(negedge clk);
    rst_i = 0; ID_PC_i = 0; EX_Branch_i = 0;
    #1;
    chk("reset_predict", {31'b0, Predict_o}, 32'd1);
    chk("reset_cnt", {16'b0, MispredCnt_o}, 32'd0);
    chk("reset_flush", {31'b0, Flush_o}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h40, 32'h40, 0);
    step(0, 1, 1, 0, 32'h40, 32'h40, 0);
    chk("snt_predict", {31'b0, Predict_o}, 32'd0);
    chk("mispred_one", {16'b0, MispredCnt_o}, 32'd1);
    EX_Branch_i = 1; EX_Predict_i = 1; EX_Taken_i = 0; EX_PC_i = 32'h40; #1;
    chk("nt_flush", {31'b0, Flush_o}, 32'd1);
    chk("nt_redirect", RedirectPC_o, 32'h44);
    EX_Predict_i = 0; EX_Taken_i = 1; EX_PC_i = 32'h100; EX_Imm_i = 32'hFFFFFFF8; #1;
    chk("tk_flush", {31'b0, Flush_o}, 32'd1);
    chk("tk_redirect", RedirectPC_o, 32'hF0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 32'h10, 32'h10, 0);
    chk("same_cycle_next", {31'b0, Predict_o}, 32'd1);
    step(0, 0, 0, 0, 32'h10, 32'h10, 0);
`ifdef BPU_BHT_EN
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h04, 32'h04, 0);
    ID_PC_i = 32'h08; EX_Branch_i = 0; #1;
    chk("bht_isolate", {31'b0, Predict_o}, 32'd1);
    ID_PC_i = 32'h44; #1;
    chk("bht_alias", {31'b0, Predict_o}, 32'd0);
    ID_PC_i = 32'h04; #1;
    chk("bht_trained", {31'b0, Predict_o}, 32'd0);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, $urandom);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65537; i++) step(0, 1, 1, 0, $urandom, $urandom, $urandom);
    chk("sat_cnt", {16'b0, MispredCnt_o}, 32'h0000FFFF);
    step(1, 1, 1, 0, 0, 32'h40, 0);
    chk("sat_reset", {16'b0, MispredCnt_o}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ID_PC_i  input  32  PC of the instruction in ID; used for the prediction lookup.
REQ-004 SHALL have Predict_o  output  1  prediction for the ID-stage branch (1 = taken); fed into ID/EX Predict.
REQ-005 SHALL have EX_Branch_i  input  1  a valid conditional branch is in EX (ID/EX Branch output).
REQ-006 SHALL have EX_Predict_i  input  1  prediction carried through ID/EX for that branch.
REQ-007 SHALL have EX_Taken_i  input  1  actual outcome from the EX comparator.
REQ-008 SHALL have EX_PC_i, EX_Imm_i  input  32 each  PC and immediate carried through ID/EX.
REQ-009 SHALL have Flush_o  output  1  misprediction; drives Flush_i of IF/ID and ID/EX.
REQ-010 SHALL have RedirectPC_o  output  32  corrected fetch PC; valid when Flush_o = 1.
REQ-011 SHALL have MispredCnt_o  output  16  saturating misprediction count.

Function
REQ-012 SHALL keep a 2-bit saturating counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-013 SHALL drive Predict_o combinationally as bit[1] of the counter selected for ID_PC_i, with no cycle of latency.
REQ-014 SHALL update the counter at the edge when EX_Branch_i=1: ST->ST, WT->ST, WNT->WT, SNT->WNT when EX_Taken_i=1.
REQ-015 SHALL update the counter at the edge when EX_Branch_i=1: ST->WT, WT->WNT, WNT->SNT, SNT->SNT when EX_Taken_i=0.
REQ-016 SHALL leave all counters unchanged when EX_Branch_i=0, including flushed bubbles, where Branch=0.
REQ-017 SHALL compute Flush_o combinationally as EX_Branch_i & (EX_Predict_i ^ EX_Taken_i).
REQ-018 SHALL set RedirectPC_o = EX_PC_i + (EX_Imm_i << 1) when EX_Taken_i=1, else EX_PC_i + 4.
REQ-019 SHALL compute RedirectPC_o modulo 2^32, with the carry discarded.
REQ-020 SHALL drive RedirectPC_o even when Flush_o=0; consumers ignore it then.
REQ-021 SHALL make Predict_o reflect the pre-update value when the ID lookup and the EX update hit the same counter in the same cycle, with no bypass.
REQ-022 SHALL increment MispredCnt_o by 1 at each edge where Flush_o=1, holding at 16'hFFFF.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, set every counter to ST (11) and MispredCnt_o to 0.
REQ-024 SHALL let rst_i override a simultaneous update; Predict_o SHALL read 1 for every PC after reset.
REQ-025 SHALL keep Flush_o and RedirectPC_o purely combinational with no reset term.

Configuration
REQ-026 SHALL, with BPU_BHT_EN defined, hold 16 counters indexed by PC[5:2]: lookup uses ID_PC_i[5:2], update uses EX_PC_i[5:2].
REQ-027 SHALL, without BPU_BHT_EN, hold a single global counter and ignore PC bits for indexing.

Structure
REQ-028 SHALL place the state encodings (SNT/WNT/WT/ST), the reset state, BHT depth 16, index width 4 and the counter width 16 in the shared package bpu_pkg.
REQ-029 SHALL implement the 2-bit counter and its next-state logic as sub-module sat_counter2, instantiated once or 16 times.

Verification
REQ-030 SHALL cover reset: after reset, ID_PC_i=0x0 gives Predict_o=1, MispredCnt_o=0 and Flush_o=0.
REQ-031 SHALL cover a mispredict: after three not-taken updates (EX_Branch_i=1, EX_Taken_i=0), the state is SNT and Predict_o=0; with EX_Predict_i=1, EX_Taken_i=0, EX_PC_i=0x40, the result is Flush_o=1, RedirectPC_o=0x44 and a count of 1.
REQ-032 SHALL cover the redirect target: EX_Taken_i=1, EX_Predict_i=0, EX_PC_i=0x100, EX_Imm_i=0xFFFFFFF8 gives Flush_o=1 and RedirectPC_o=0xF0.
REQ-033 SHALL cover same-cycle update and lookup: EX update not-taken and ID lookup on the same index with state ST gives Predict_o=1 that cycle and 1 (WT) the next.
REQ-034 SHALL cover BHT isolation with BPU_BHT_EN: training 0x04 to SNT leaves Predict_o=1 for 0x08, while 0x44 aliases 0x04 and reads 0.
REQ-035 SHALL cover counter saturation: 65537 forced mispredicts give MispredCnt_o=0xFFFF, and rst_i mid-stream returns it to 0 next edge.
